// File: rtl/rescue_prime_stream_if_pkg.sv
// Shared types and geometry for the Rescue-Prime streaming wrapper.
// Optional range check is enabled by the RESCUE_RANGE_CHECK_EN macro.
package rescue_prime_pkg;

    localparam int N_BITS_DEF     = 254;
    localparam int STATE_SIZE_DEF = 3;
    localparam int NUM_LANES_DEF  = 13;
    localparam int NW             = STATE_SIZE_DEF * NUM_LANES_DEF;
    localparam int CNT_W          = $clog2(NW + 1);

    localparam logic [N_BITS_DEF-1:0] PRIME_MODULUS_DEF =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    typedef logic [N_BITS_DEF-1:0] fe_t;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        UNLOAD = 2'd3
    } state_t;

endpackage

// File: rtl/rescue_prime_stream_if_if.sv
// Valid/ready element stream with end-of-block marker.
interface rescue_prime_stream_if_if #(
    parameter int N_BITS = 254
);
    logic              valid;
    logic              ready;
    logic              last;
    logic [N_BITS-1:0] data;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/rescue_prime_stream_if_range_check.sv
// Canonical-range check: flags words >= modulus and reduces them once.
module rescue_prime_range_check #(
    parameter int                N_BITS        = 254,
    parameter logic [N_BITS-1:0] PRIME_MODULUS = '1
) (
    input  logic [N_BITS-1:0] data_in,
    output logic [N_BITS-1:0] data_out,
    output logic              out_of_range
);
    assign out_of_range = (data_in >= PRIME_MODULUS);
    assign data_out     = out_of_range ? (data_in - PRIME_MODULUS) : data_in;
endmodule

// File: rtl/rescue_prime_stream_if.sv
// Streaming loader/unloader around the Rescue-Prime permutation core.
// Define RESCUE_RANGE_CHECK_EN to reduce and flag non-canonical input words.
module rescue_prime_stream_if
    import rescue_prime_pkg::*;
#(
    parameter int                N_BITS        = N_BITS_DEF,
    parameter int                STATE_SIZE    = STATE_SIZE_DEF,
    parameter int                NUM_LANES     = NUM_LANES_DEF,
    parameter logic [N_BITS-1:0] PRIME_MODULUS = N_BITS'(PRIME_MODULUS_DEF)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    rescue_prime_stream_if_if.slave               in_s,
    rescue_prime_stream_if_if.master              out_m,
    output logic                                  perm_start,
    output logic [STATE_SIZE*NUM_LANES*N_BITS-1:0] perm_state_in,
    input  logic                                  perm_done,
    input  logic [STATE_SIZE*NUM_LANES*N_BITS-1:0] perm_state_out,
    output logic                                  busy,
    output logic                                  err_range
);
    localparam int            NWORDS   = STATE_SIZE * NUM_LANES;
    localparam int            CW       = $clog2(NWORDS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);

    state_t            state, state_nxt;
    logic [CW-1:0]     wr_cnt, rd_cnt;
    logic [N_BITS-1:0] ibuf [NWORDS];
    logic [N_BITS-1:0] obuf [NWORDS];
    logic [N_BITS-1:0] store_word;
    logic              in_ready_int, out_valid_int;
    logic              in_xfer, out_xfer, block_end;

    assign in_ready_int  = (state == LOAD);
    assign out_valid_int = (state == UNLOAD);
    assign in_s.ready    = in_ready_int;
    assign out_m.valid   = out_valid_int;
    assign out_m.last    = out_valid_int && (rd_cnt == LAST_IDX);
    assign out_m.data    = obuf[rd_cnt];
    assign perm_start    = (state == START);
    assign busy          = (state != LOAD);

    assign in_xfer   = in_s.valid && in_ready_int;
    assign out_xfer  = out_valid_int && out_m.ready;
    assign block_end = in_xfer && (in_s.last || (wr_cnt == LAST_IDX));

`ifdef RESCUE_RANGE_CHECK_EN
    logic out_of_range;

    rescue_prime_range_check #(
        .N_BITS        (N_BITS),
        .PRIME_MODULUS (PRIME_MODULUS)
    ) u_range_check (
        .data_in      (in_s.data),
        .data_out     (store_word),
        .out_of_range (out_of_range)
    );

    always_ff @(posedge clk) begin
        if (reset)                        err_range <= 1'b0;
        else if (in_xfer && out_of_range) err_range <= 1'b1;
    end
`else
    logic unused_modulus;

    assign store_word     = in_s.data;
    assign err_range      = 1'b0;
    assign unused_modulus = ^PRIME_MODULUS;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (block_end) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (perm_done) state_nxt = UNLOAD;
            UNLOAD:  if (out_xfer && (rd_cnt == LAST_IDX)) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Loading on an early in_last zeroes every slot above it so stale words never reach the core.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
            for (int j = 0; j < NWORDS; j++) begin
                ibuf[j] <= '0;
                obuf[j] <= '0;
            end
        end else begin
            case (state)
                LOAD: if (in_xfer) begin
                    wr_cnt <= wr_cnt + CW'(1);
                    for (int j = 0; j < NWORDS; j++) begin
                        if (CW'(j) == wr_cnt)                    ibuf[j] <= store_word;
                        else if (in_s.last && (CW'(j) > wr_cnt)) ibuf[j] <= '0;
                    end
                end
                WAIT: if (perm_done) begin
                    wr_cnt <= '0;
                    for (int j = 0; j < NWORDS; j++)
                        obuf[j] <= perm_state_out[j*N_BITS +: N_BITS];
                end
                UNLOAD: if (out_xfer)
                    rd_cnt <= (rd_cnt == LAST_IDX) ? '0 : rd_cnt + CW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        perm_state_in = '0;
        for (int j = 0; j < NWORDS; j++)
            perm_state_in[j*N_BITS +: N_BITS] = ibuf[j];
    end

endmodule

// File: tb/tb_rescue_prime_stream_if.sv
// Randomised self-checking bench for rescue_prime_stream_if with a stub permutation core.
module tb_rescue_prime_stream_if;
    import rescue_prime_pkg::*;

    localparam int             NB  = 254;
    localparam int             NWL = 39;
    localparam logic [NB-1:0]  P   = PRIME_MODULUS_DEF;
    localparam logic [NB-1:0]  ONE = 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rescue_prime_stream_if_if #(.N_BITS(NB)) in_s ();
    rescue_prime_stream_if_if #(.N_BITS(NB)) out_m ();

    logic              perm_start, perm_done, busy, err_range;
    logic [NWL*NB-1:0] perm_state_in, perm_state_out;

    rescue_prime_stream_if dut (
        .clk            (clk),
        .reset          (reset),
        .in_s           (in_s),
        .out_m          (out_m),
        .perm_start     (perm_start),
        .perm_state_in  (perm_state_in),
        .perm_done      (perm_done),
        .perm_state_out (perm_state_out),
        .busy           (busy),
        .err_range      (err_range)
    );

    int checks = 0;
    int errors = 0;

    // Stub core: latches the state on perm_start, answers word+1 a few cycles later.
    int                stub_cnt  = 0;
    logic [NWL*NB-1:0] stub_q    = '0;
    logic              spur      = 1'b0;
    logic [NWL*NB-1:0] spur_data = '0;

    always @(posedge clk) begin
        if (perm_start) begin
            stub_cnt <= 5;
            stub_q   <= perm_state_in;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
        end
    end

    always_comb begin
        perm_done      = spur || (stub_cnt == 1);
        perm_state_out = '0;
        for (int j = 0; j < NWL; j++)
            perm_state_out[j*NB +: NB] = spur ? spur_data[j*NB +: NB] : stub_q[j*NB +: NB] + ONE;
    end

    // Reference model: block contents as the specification defines them.
    logic [NB-1:0] src     [NWL];
    logic [NB-1:0] exp_in  [NWL];
    logic [NB-1:0] exp_out [NWL];
    bit            model_err = 1'b0;

    function automatic logic [NB-1:0] rand_word();
        logic [255:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        return t[NB-1:0];
    endfunction

    function automatic logic [NB-1:0] stored(input logic [NB-1:0] w);
`ifdef RESCUE_RANGE_CHECK_EN
        return (w >= P) ? w - P : w;
`else
        return w;
`endif
    endfunction

    task automatic send_block(input int n, input bit with_last, input bit gaps);
        int i = 0;
        int guard = 0;
        for (int j = 0; j < NWL; j++) exp_in[j] = '0;
        while (i < n && guard < 4*NWL + 20) begin
            @(negedge clk);
            guard++;
            in_s.valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_s.data  = src[i];
            in_s.last  = with_last && (i == n - 1);
            if (in_s.valid) begin
                checks++;
                if (in_s.ready !== 1'b1) begin
                    errors++;
                    $display("FAIL in_ready_load word %0d got %b exp 1", i, in_s.ready);
                end
                exp_in[i] = stored(src[i]);
`ifdef RESCUE_RANGE_CHECK_EN
                if (src[i] >= P) model_err = 1'b1;
`endif
                i++;
            end
        end
        checks++;
        if (i < n) begin
            errors++;
            $display("FAIL send_timeout got %0d words exp %0d", i, n);
        end
        @(negedge clk);
        in_s.valid = 1'b0;
        in_s.last  = 1'b0;
        checks++;
        if (perm_start !== 1'b1) begin
            errors++;
            $display("FAIL perm_start_pulse got %b exp 1", perm_start);
        end
        checks++;
        if (busy !== 1'b1 || in_s.ready !== 1'b0) begin
            errors++;
            $display("FAIL start_state got busy=%b in_ready=%b exp busy=1 in_ready=0", busy, in_s.ready);
        end
        for (int j = 0; j < NWL; j++) begin
            checks++;
            if (perm_state_in[j*NB +: NB] !== exp_in[j]) begin
                errors++;
                $display("FAIL perm_state_in[%0d] got %h exp %h", j, perm_state_in[j*NB +: NB], exp_in[j]);
            end
        end
        @(negedge clk);
        checks++;
        if (perm_start !== 1'b0) begin
            errors++;
            $display("FAIL perm_start_width got %b exp 0", perm_start);
        end
        for (int j = 0; j < NWL; j++) exp_out[j] = exp_in[j] + ONE;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
    task automatic collect_block(input int mode, input bit spur_pulse);
        int idx = 0;
        int cyc = 0;
        int g = 0;
        bit r;
        while (out_m.valid !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (out_m.valid !== 1'b1) begin
            errors++;
            $display("FAIL out_valid_timeout got %b exp 1", out_m.valid);
            return;
        end
        while (idx < NWL && cyc < 8*NWL) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_m.ready = r;
            spur = spur_pulse && (cyc == 2);
            if (spur)
                for (int j = 0; j < NWL; j++) spur_data[j*NB +: NB] = rand_word();
            checks++;
            if (out_m.valid !== 1'b1) begin
                errors++;
                $display("FAIL out_valid word %0d got %b exp 1", idx, out_m.valid);
            end
            checks++;
            if (out_m.data !== exp_out[idx]) begin
                errors++;
                $display("FAIL out_data word %0d got %h exp %h", idx, out_m.data, exp_out[idx]);
            end
            checks++;
            if (out_m.last !== (idx == NWL - 1)) begin
                errors++;
                $display("FAIL out_last word %0d got %b exp %b", idx, out_m.last, idx == NWL - 1);
            end
            checks++;
            if (in_s.ready !== 1'b0) begin
                errors++;
                $display("FAIL in_ready_unload word %0d got %b exp 0", idx, in_s.ready);
            end
            if (r) idx++;
            cyc++;
            @(negedge clk);
        end
        spur        = 1'b0;
        out_m.ready = 1'b0;
        checks++;
        if (idx != NWL) begin
            errors++;
            $display("FAIL unload_count got %0d exp %0d", idx, NWL);
        end
        checks++;
        if (out_m.valid !== 1'b0 || in_s.ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL back_to_load got valid=%b in_ready=%b busy=%b exp 0 1 0", out_m.valid, in_s.ready, busy);
        end
        checks++;
        if (err_range !== model_err) begin
            errors++;
            $display("FAIL err_range got %b exp %b", err_range, model_err);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (in_s.ready !== 1'b1 || out_m.valid !== 1'b0 || out_m.last !== 1'b0 ||
            perm_start !== 1'b0 || busy !== 1'b0 || err_range !== 1'b0) begin
            errors++;
            $display("FAIL %s got in_ready=%b out_valid=%b out_last=%b start=%b busy=%b err=%b exp 1 0 0 0 0 0",
                     name, in_s.ready, out_m.valid, out_m.last, perm_start, busy, err_range);
        end
        checks++;
        if (perm_state_in !== '0) begin
            errors++;
            $display("FAIL %s_state got nonzero perm_state_in exp all zero", name);
        end
        checks++;
        if (out_m.data !== '0) begin
            errors++;
            $display("FAIL %s_out_data got %h exp 0", name, out_m.data);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        model_err = 1'b0;
        check_reset_values("reset");
    endtask

    task automatic test_full_block();
        for (int i = 0; i < NWL; i++) src[i] = NB'(i + 1);
        send_block(NWL, 1'b0, 1'b0);
        collect_block(0, 1'b0);
    endtask

    task automatic test_early_last();
        for (int i = 0; i < 5; i++) src[i] = NB'(32'hA + i);
        send_block(5, 1'b1, 1'b0);
        collect_block(0, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < NWL; i++) src[i] = rand_word();
        send_block(NWL, 1'b1, 1'b1);
        collect_block(1, 1'b0);
    endtask

    task automatic test_random_blocks();
        for (int b = 0; b < 4; b++) begin
            int n;
            n = $urandom_range(1, NWL);
            for (int i = 0; i < n; i++) src[i] = rand_word();
            send_block(n, (n < NWL) || ($urandom_range(0, 1) == 1), 1'b1);
            collect_block(2, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NWL; i++) src[i] = NB'(100*b + i);
            send_block(NWL, 1'b0, 1'b0);
            collect_block(0, 1'b0);
        end
    endtask

    task automatic test_spurious_done();
        @(negedge clk);
        for (int j = 0; j < NWL; j++) spur_data[j*NB +: NB] = rand_word();
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_s.ready !== 1'b1 || out_m.valid !== 1'b0) begin
            errors++;
            $display("FAIL spur_load got busy=%b in_ready=%b out_valid=%b exp 0 1 0", busy, in_s.ready, out_m.valid);
        end
        for (int j = 0; j < NWL; j++) begin
            checks++;
            if (perm_state_in[j*NB +: NB] !== exp_in[j]) begin
                errors++;
                $display("FAIL spur_ibuf[%0d] got %h exp %h", j, perm_state_in[j*NB +: NB], exp_in[j]);
            end
        end
        for (int i = 0; i < 7; i++) src[i] = rand_word();
        send_block(7, 1'b1, 1'b0);
        collect_block(0, 1'b1);
    endtask

    task automatic test_reset_wait();
        bit stray = 1'b0;
        for (int i = 0; i < NWL; i++) src[i] = rand_word();
        send_block(NWL, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || out_m.valid !== 1'b0) begin
            errors++;
            $display("FAIL in_wait got busy=%b out_valid=%b exp 1 0", busy, out_m.valid);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_err = 1'b0;
        for (int j = 0; j < NWL; j++) exp_in[j] = '0;
        check_reset_values("reset_wait");
        repeat (10) begin
            @(negedge clk);
            if (out_m.valid !== 1'b0 || busy !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL late_done got out_valid/busy raised exp idle LOAD");
        end
    endtask

    task automatic test_range();
        src[0] = P + NB'(3);
        src[1] = NB'(7);
        src[2] = P;
        send_block(3, 1'b1, 1'b0);
        checks++;
        if (err_range !== model_err) begin
            errors++;
            $display("FAIL err_range_set got %b exp %b", err_range, model_err);
        end
        collect_block(0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_err = 1'b0;
        @(negedge clk);
        checks++;
        if (err_range !== 1'b0) begin
            errors++;
            $display("FAIL err_range_clear got %b exp 0", err_range);
        end
    endtask

    initial begin
        in_s.valid  = 1'b0;
        in_s.data   = '0;
        in_s.last   = 1'b0;
        out_m.ready = 1'b0;
        test_reset();
        test_full_block();
        test_early_last();
        test_backpressure();
        test_random_blocks();
        test_back_to_back();
        test_spurious_done();
        test_reset_wait();
        test_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rescue_prime_stream_if.md
Name: rescue_prime_stream_if

Overview:
- Streaming front/back end for the Rescue-Prime permutation core.
- Gathers NUM_LANES*STATE_SIZE field elements from a valid/ready input stream, presents them as one flattened state to the core, and starts it.
- Captures the result and drains it through a valid/ready output stream with end-of-block marking.
- Generalises the fixed 39-word wr/rd pointer loader with parametrised geometry, backpressure, early-last zero padding and explicit core handshake ports.

Parameters:
- N_BITS, 254, field element width.
- STATE_SIZE, 3, elements per lane.
- NUM_LANES, 13, parallel permutation lanes.
- PRIME_MODULUS, 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001, field modulus, used only by the optional check.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input word valid.
- in_data  in  N_BITS  input element.
- in_last  in  1  final word of block, qualified by in_valid.
- in_ready  out  1  wrapper accepts a word.
- out_valid  out  1  output word valid.
- out_data  out  N_BITS  output element.
- out_last  out  1  final word of block.
- out_ready  in  1  downstream accepts.
- perm_start  out  1  one-cycle start pulse to core.
- perm_state_in  out  NW*N_BITS  flattened core input; word k at bits [k*N_BITS +: N_BITS].
- perm_done  in  1  core completion.
- perm_state_out  in  NW*N_BITS  flattened core output, same layout.
- busy  out  1  state != LOAD.
- err_range  out  1  sticky non-canonical input flag (optional feature).

Behaviour:
- Geometry:
  - NW = STATE_SIZE*NUM_LANES.
  - Stream word k maps to lane k/STATE_SIZE, element k%STATE_SIZE.
  - Counters are $clog2(NW+1) bits.
- Reset (synchronous, all outputs):
  - State LOAD; wr_cnt = rd_cnt = 0; input and output buffers cleared to 0.
  - in_ready = 1, out_valid = 0, out_last = 0, perm_start = 0, busy = 0, err_range = 0.
  - Reset mid-block discards all data; a core already running is ignored, and its later perm_done is dropped in LOAD.
- LOAD:
  - in_ready = 1. Transfer occurs on in_valid && in_ready, writing ibuf[wr_cnt] and incrementing wr_cnt.
  - A transfer with in_last, or a transfer of word NW-1, moves to START. Words above the last written index are forced to 0 (zero padding).
  - in_last on word NW-1 is normal. Without in_last, the block still closes at NW words.
- START:
  - perm_start = 1 for exactly one cycle, which is the cycle after the last accepted word.
  - in_ready = 0; next state WAIT.
- WAIT:
  - in_ready = 0. perm_state_in stays stable from START until perm_done.
  - First cycle with perm_done = 1: register perm_state_out into obuf, clear wr_cnt, go to UNLOAD.
  - perm_done outside WAIT is ignored.
- UNLOAD:
  - out_valid = 1 from the cycle after perm_done; out_data = obuf[rd_cnt].
  - out_last = 1 when rd_cnt == NW-1. All NW words are emitted, padded or not.
  - Transfer on out_valid && out_ready advances rd_cnt.
  - The transfer of word NW-1 returns to LOAD with rd_cnt = 0 and in_ready = 1 on the next cycle.
  - out_data and out_last hold while out_valid && !out_ready.
- Input valid/ready: in_ready is a registered state decode and does not depend on in_valid.
- Throughput: minimum block period = NW + 2 + core latency + NW cycles (no overlap).

Optional Feature:
- Macro: RESCUE_RANGE_CHECK_EN.
- With the macro:
  - Each accepted in_data >= PRIME_MODULUS sets err_range sticky until reset.
  - The word is stored as in_data - PRIME_MODULUS (single conditional subtract).
- Without the macro: err_range is tied 0, no comparator is built, and words are stored unchanged.

Decomposition:
- Package rescue_prime_pkg holds:
  - state enum {LOAD, START, WAIT, UNLOAD};
  - localparams NW and CNT_W;
  - default PRIME_MODULUS constant;
  - field element typedef logic [N_BITS-1:0].
- One natural sub-module: rescue_prime_range_check (compare and conditional subtract), instantiated only under RESCUE_RANGE_CHECK_EN.

Test Plan:
- Full block: send words 1..39 with in_valid held high, out_ready = 1, and a stub core that returns input+1 with perm_done after 5 cycles. Expect:
  - perm_start one cycle after word 39;
  - outputs 2..40 in order;
  - out_last on the 39th output only.
- Early last: send 5 words (0xA..0xE) with in_last on the 5th. Expect perm_state_in words 0-4 = 0xA..0xE, words 5-38 = 0, and 39 outputs.
- Backpressure: toggle out_ready 1,0,0,1 during UNLOAD. Expect out_data stable across stalls, no word lost or duplicated, and in_ready = 0 until the final out transfer.
- Spurious done: pulse perm_done in LOAD and in UNLOAD. Expect no state change and no obuf update.
- Reset mid-WAIT: assert reset for one cycle. Expect LOAD, in_ready = 1, and all outputs at reset values. The stub's later perm_done is ignored.
- With RESCUE_RANGE_CHECK_EN: send word PRIME_MODULUS+3. Expect stored word 3 and err_range = 1 until reset. Without the macro: err_range stays 0 and the word is stored unchanged.
